// File: rtl/mult16_mac_pkg.sv
// mult16_mac_pkg: shared widths and FSM state type for the multiplier MAC accumulator.
package mult16_mac_pkg;
  localparam int PROD_W    = 32;
  localparam int ACC_W_DEF = 40;
  localparam int CNT_W_DEF = 8;
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} mac_state_t;
endpackage

// File: rtl/mult16_mac_add.sv
// mult16_mac_add: ACC_W-bit accumulate adder with carry out.
// Define MULT16_MAC_SAT_EN to clamp the sum to all-ones on overflow instead of wrapping.
module mult16_mac_add
  import mult16_mac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  a,
  input  logic [PROD_W-1:0] b,
  output logic [ACC_W-1:0]  sum,
  output logic              carry
);
  logic [ACC_W:0] wide;
  assign wide  = {1'b0, a} + {{(ACC_W + 1 - PROD_W){1'b0}}, b};
  assign carry = wide[ACC_W];
`ifdef MULT16_MAC_SAT_EN
  assign sum = carry ? {ACC_W{1'b1}} : wide[ACC_W-1:0];
`else
  assign sum = wide[ACC_W-1:0];
`endif
endmodule

// File: rtl/mult16_mac_accum.sv
// mult16_mac_accum: accumulates a valid/ready stream of 32-bit products into a dot-product sum.
// Saturating accumulation is selected by MULT16_MAC_SAT_EN (see mult16_mac_add).
module mult16_mac_accum
  import mult16_mac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] product,
  input  logic              in_last,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc_data,
  output logic [CNT_W-1:0]  term_cnt,
  output logic              acc_ovf
);
  mac_state_t       state, state_nxt;
  logic [ACC_W-1:0] sum;
  logic             carry, take, flush;
  mult16_mac_add #(.ACC_W(ACC_W)) u_add (
    .a    (acc_data),
    .b    (product),
    .sum  (sum),
    .carry(carry)
  );
  assign in_ready  = state != HOLD;
  assign out_valid = state == HOLD;
  assign take      = in_valid && in_ready && !clear;
  assign flush     = clear || (out_valid && out_ready);
  always_comb begin
    state_nxt = state;
    if (flush) state_nxt = IDLE;
    else if (take) state_nxt = in_last ? HOLD : ACCUM;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end
  // clear wins over a same-cycle beat; a completed handshake also empties the sum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_data <= '0;
      term_cnt <= '0;
      acc_ovf  <= 1'b0;
    end else if (flush) begin
      acc_data <= '0;
      term_cnt <= '0;
      acc_ovf  <= 1'b0;
    end else if (take) begin
      acc_data <= sum;
      term_cnt <= (&term_cnt) ? term_cnt : term_cnt + 1'b1;
      acc_ovf  <= acc_ovf | carry;
    end
  end
endmodule
